// File: rtl/muldiv_seq_pkg.sv
// rtl/muldiv_seq_pkg.sv - shared types and constants for the MUL/DIV sequencer
package muldiv_seq_pkg;

    // Sequencer state encoding.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } md_state_t;

    // Iteration counter width; wraps back to zero after the last iteration.
    localparam int ITERS_W = 3;

    // Default alu op codes and iteration count used by the cpu.
    localparam logic [3:0] MD_OP_ADD = 4'h0;
    localparam logic [3:0] MD_OP_SUB = 4'h1;
    localparam int         MD_ITERS  = 8;

endpackage

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle 8-bit MUL/DIV sequencer driving the shared alu
import muldiv_seq_pkg::*;

module muldiv_seq #(
    parameter logic [3:0] OP_ADD = MD_OP_ADD,
    parameter logic [3:0] OP_SUB = MD_OP_SUB,
    parameter int         ITERS  = MD_ITERS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       is_div,
    input  logic [7:0] op_a,
    input  logic [7:0] op_b,
    output logic       busy,
    output logic       done,
    output logic [7:0] result_lo,
    output logic [7:0] result_hi,
    output logic       carry_out,
    output logic       div_by_zero,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_op,
    input  logic [7:0] alu_c,
    input  logic       alu_cf
);

    localparam logic [ITERS_W-1:0] LAST_ITER = ITERS_W'(ITERS - 1);

    md_state_t          state_q;
    logic [ITERS_W-1:0] cnt_q;
    logic               div_q;
    logic               dz_q;
    // MUL: multiplicand. DIV: divisor. This is the fixed alu operand.
    logic [7:0]         opnd_q;
    // MUL: product high byte. DIV: partial remainder (always fits 8 bits).
    logic [7:0]         hi_q;
    // MUL: multiplier shifting out / product low byte. DIV: dividend shifting out / quotient.
    logic [7:0]         lo_q;

    logic               busy_q;
    logic               done_q;
    logic [7:0]         res_lo_q;
    logic [7:0]         res_hi_q;
    logic               carry_q;
    logic               dz_out_q;

    logic [8:0]         shl_rem;
    logic [7:0]         hi_d;
    logic [7:0]         lo_d;

    assign busy        = busy_q;
    assign done        = done_q;
    assign result_lo   = res_lo_q;
    assign result_hi   = res_hi_q;
    assign carry_out   = carry_q;
    assign div_by_zero = dz_out_q;

    // Remainder shifted left with the next dividend bit; bit 8 means it certainly exceeds the divisor.
    assign shl_rem = {hi_q, lo_q[7]};

    // Alu operand mux; only driven while iterating so the cpu can share the alu otherwise.
    always_comb begin
        alu_a  = 8'h00;
        alu_b  = 8'h00;
        alu_op = OP_ADD;
        if (state_q == S_RUN) begin
            if (div_q) begin
                alu_a  = shl_rem[7:0];
                alu_b  = opnd_q;
                alu_op = OP_SUB;
            end else begin
                alu_a  = opnd_q;
                alu_b  = hi_q;
                alu_op = OP_ADD;
            end
        end
    end

    // One shift-add (MUL) or restoring shift-subtract (DIV) step from the current alu result.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (div_q) begin
            if (shl_rem[8] || !alu_cf) begin
                hi_d = alu_c;
                lo_d = {lo_q[6:0], 1'b1};
            end else begin
                hi_d = shl_rem[7:0];
                lo_d = {lo_q[6:0], 1'b0};
            end
        end else begin
            if (lo_q[0]) begin
                hi_d = {alu_cf, alu_c[7:1]};
                lo_d = {alu_c[0], lo_q[7:1]};
            end else begin
                hi_d = {1'b0, hi_q[7:1]};
                lo_d = {hi_q[0], lo_q[7:1]};
            end
        end
    end

    // Sequencer FSM with registered status and result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            div_q    <= 1'b0;
            dz_q     <= 1'b0;
            opnd_q   <= 8'h00;
            hi_q     <= 8'h00;
            lo_q     <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            res_lo_q <= 8'h00;
            res_hi_q <= 8'h00;
            carry_q  <= 1'b0;
            dz_out_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q  <= S_RUN;
                        cnt_q    <= '0;
                        div_q    <= is_div;
                        dz_q     <= is_div && (op_b == 8'h00);
                        opnd_q   <= is_div ? op_b : op_a;
                        lo_q     <= is_div ? op_a : op_b;
                        hi_q     <= 8'h00;
                        busy_q   <= 1'b1;
                        res_lo_q <= 8'h00;
                        res_hi_q <= 8'h00;
                        carry_q  <= 1'b0;
                        dz_out_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + ITERS_W'(1);
                    if (cnt_q == LAST_ITER) begin
                        state_q  <= S_DONE;
                        done_q   <= 1'b1;
                        res_lo_q <= lo_d;
                        res_hi_q <= hi_d;
                        carry_q  <= (hi_d != 8'h00);
                        dz_out_q <= dz_q;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
